// File: rtl/modport_ram.sv
// Single-clock dual-port RAM: one write port, one registered read port.
// Same-address read-during-write returns the incoming data (write-first).
module modport_ram #(
    parameter int RAM_WIDTH = 64,
    parameter int ADDR_SIZE = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic [ADDR_SIZE-1:0] wr_address,
    input  logic                 write,
    input  logic [ADDR_SIZE-1:0] rd_address,
    input  logic                 read,
    output logic [RAM_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [RAM_WIDTH-1:0] mem [DEPTH];
    logic                 bypass;

    assign bypass = write && (rd_address == wr_address);

    // Reset clears every word so unwritten locations always read back as zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[wr_address] <= data_in;
        end
    end

    // data_out only carries data in the cycle after a read; otherwise it is zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_out <= '0;
        end else if (read) begin
            data_out <= bypass ? data_in : mem[rd_address];
        end else begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_modport_ram.sv
// Directed testbench for modport_ram; inputs change on the falling edge,
// data_out is checked on the falling edge after the sampling rising edge.
module tb_modport_ram;

    logic        clk;
    logic        resetn;
    logic [63:0] data_in;
    logic [11:0] wr_address;
    logic        write;
    logic [11:0] rd_address;
    logic        read;
    logic [63:0] data_out;

    int check_count;
    int pass_count;

    modport_ram #(.RAM_WIDTH(64), .ADDR_SIZE(12)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .wr_address(wr_address),
        .write     (write),
        .rd_address(rd_address),
        .read      (read),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge sample them, return at the next falling edge.
    task automatic applyStimulus(input logic rst_n, input logic wr, input logic [11:0] wa,
                                 input logic [63:0] din, input logic rd, input logic [11:0] ra);
        resetn     = rst_n;
        write      = wr;
        wr_address = wa;
        data_in    = din;
        read       = rd;
        rd_address = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        resetn      = 1'b0;
        write       = 1'b0;
        read        = 1'b0;
        wr_address  = '0;
        rd_address  = '0;
        data_in     = '0;
        @(negedge clk);

        // Reset then read untouched locations
        applyStimulus(1'b0, 1'b1, 12'd0, 64'hFFFF, 1'b1, 12'd0);
        checkOutput("reset_cycle1", data_out, 64'h0);
        applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b0, 12'd0);
        checkOutput("reset_cycle2", data_out, 64'h0);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd0);
        checkOutput("reset_read0", data_out, 64'h0);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd1);
        checkOutput("reset_read1", data_out, 64'h0);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd4095);
        checkOutput("reset_read4095", data_out, 64'h0);

        // Write then read back, then idle read
        applyStimulus(1'b1, 1'b1, 12'd5, 64'hDEADBEEF_01234567, 1'b0, 12'd0);
        checkOutput("idle_after_write", data_out, 64'h0);
        applyStimulus(1'b1, 1'b0, 12'd5, 64'h1234, 1'b1, 12'd5);
        checkOutput("readback5", data_out, 64'hDEADBEEF_01234567);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b0, 12'd5);
        checkOutput("idle_zero", data_out, 64'h0);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd5);
        checkOutput("write_disabled_keeps5", data_out, 64'hDEADBEEF_01234567);

        // Same-address bypass
        applyStimulus(1'b1, 1'b1, 12'd10, 64'hA5A5, 1'b1, 12'd10);
        checkOutput("bypass10", data_out, 64'hA5A5);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd10);
        checkOutput("reread10", data_out, 64'hA5A5);

        // Different-address simultaneous access
        applyStimulus(1'b1, 1'b1, 12'd3, 64'h11, 1'b0, 12'd0);
        applyStimulus(1'b1, 1'b1, 12'd7, 64'h22, 1'b0, 12'd0);
        applyStimulus(1'b1, 1'b1, 12'd7, 64'h33, 1'b1, 12'd3);
        checkOutput("diff_read3", data_out, 64'h11);
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd7);
        checkOutput("diff_read7", data_out, 64'h33);

        // Reset mid-operation wipes memory and discards the concurrent write
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b1, 12'(a), 64'(a + 1), 1'b0, 12'd0);
        end
        applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'd15);
        checkOutput("prefill15", data_out, 64'd16);
        applyStimulus(1'b0, 1'b1, 12'd0, 64'hFF, 1'b1, 12'd2);
        checkOutput("midreset_out", data_out, 64'h0);
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'(a));
            checkOutput($sformatf("post_reset_%0d", a), data_out, 64'h0);
        end

        // Back-to-back full-range stream
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b1, 1'b1, 12'(a), ~64'(a), 1'b0, 12'd0);
        end
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b1, 1'b0, 12'd0, 64'h0, 1'b1, 12'(a));
            checkOutput($sformatf("stream_%0d", a), data_out, ~64'(a));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
